// File: rtl/stopwatch_lap_cu.sv
// -----------------------------------------------------------------------------
// stopwatch_lap_cu
//
// Control unit for the stopwatch datapath. Owns the IDLE/RUN/STOP/LAP FSM,
// drives run/stop and clear into the datapath, and selects between the live
// centisecond/second count and a frozen lap snapshot for the FND controller.
// A lap view returns to the live view on its own after LAP_HOLD_CYC cycles.
//
// Parameters
//   LAP_HOLD_CYC : cycles the lap snapshot stays on the display (>= 2)
//   TMR_W        : hold timer width, 2**TMR_W >= LAP_HOLD_CYC
//
// Ports
//   clk          : system clock
//   rst          : synchronous reset, active low
//   i_runstop    : single-cycle run/stop button pulse
//   i_clear      : single-cycle clear button pulse
//   i_lap        : single-cycle lap button pulse
//   i_msec       : live centiseconds from the datapath (0..99)
//   i_sec        : live seconds from the datapath (0..59)
//   o_runstop    : datapath run_stop, 1 = counting
//   o_clear      : datapath clear, one-cycle pulse
//   o_msec       : displayed centiseconds
//   o_sec        : displayed seconds
//   o_lap_active : 1 while the lap snapshot is displayed
//   o_state      : current FSM state (IDLE=00 RUN=01 STOP=10 LAP=11)
// -----------------------------------------------------------------------------
module stopwatch_lap_cu #(
    parameter int LAP_HOLD_CYC = 300_000_000,
    parameter int TMR_W        = 29
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_runstop,
    input  logic       i_clear,
    input  logic       i_lap,
    input  logic [6:0] i_msec,
    input  logic [5:0] i_sec,
    output logic       o_runstop,
    output logic       o_clear,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic       o_lap_active,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STOP = 2'b10,
        LAP  = 2'b11
    } state_t;

    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(LAP_HOLD_CYC - 1);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [6:0]       lap_msec_q, lap_msec_d;
    logic [5:0]       lap_sec_q, lap_sec_d;
    logic             runstop_q, runstop_d;
    logic             clear_q, clear_d;

    // Priority filter: only the strongest pulse of the cycle survives, even if
    // the current state then ignores it.
    logic pick_runstop, pick_clear, pick_lap;

    always_comb begin
        pick_runstop = i_runstop;
        pick_clear   = !i_runstop && i_clear;
        pick_lap     = !i_runstop && !i_clear && i_lap;
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = '0;
        lap_msec_d = lap_msec_q;
        lap_sec_d  = lap_sec_q;
        clear_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_runstop) begin
                    state_d = RUN;
                end else if (pick_clear) begin
                    clear_d = 1'b1;
                end
            end

            RUN: begin
                if (pick_runstop) begin
                    state_d = STOP;
                end else if (pick_lap) begin
                    state_d    = LAP;
                    lap_msec_d = i_msec;
                    lap_sec_d  = i_sec;
                end
            end

            LAP: begin
                if (pick_runstop) begin
                    state_d = STOP;
                end else if (pick_lap) begin
                    // Recapture restarts the hold window from zero.
                    lap_msec_d = i_msec;
                    lap_sec_d  = i_sec;
                end else if (timer_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            STOP: begin
                if (pick_runstop) begin
                    state_d = RUN;
                end else if (pick_clear) begin
                    state_d    = IDLE;
                    clear_d    = 1'b1;
                    lap_msec_d = '0;
                    lap_sec_d  = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered from the next state so it moves together with o_state.
        runstop_d = (state_d == RUN) || (state_d == LAP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            lap_msec_q <= '0;
            lap_sec_q  <= '0;
            runstop_q  <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            lap_msec_q <= lap_msec_d;
            lap_sec_q  <= lap_sec_d;
            runstop_q  <= runstop_d;
            clear_q    <= clear_d;
        end
    end

    assign o_runstop    = runstop_q;
    assign o_clear      = clear_q;
    assign o_state      = state_q;
    assign o_lap_active = (state_q == LAP);

    // Display mux: the snapshot only while in LAP, live count otherwise.
    always_comb begin
        if (state_q == LAP) begin
            o_msec = lap_msec_q;
            o_sec  = lap_sec_q;
        end else begin
            o_msec = i_msec;
            o_sec  = i_sec;
        end
    end

endmodule

// File: tb/tb_stopwatch_lap_cu.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_lap_cu
//
// Self-checking bench for stopwatch_lap_cu with a short hold time (8 cycles).
// A behavioural model tracks the stopwatch mode, a lap countdown and the
// snapshot; directed scenarios are followed by randomized pulses and resets.
// -----------------------------------------------------------------------------
module tb_stopwatch_lap_cu;

    localparam int HOLD  = 8;
    localparam int TW    = 4;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STOP = 2;
    localparam int M_LAP  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_runstop, i_clear, i_lap;
    logic [6:0] i_msec;
    logic [5:0] i_sec;
    logic       o_runstop, o_clear, o_lap_active;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [1:0] o_state;

    int total = 0;
    int bad   = 0;

    // Model state
    int m_mode    = M_IDLE;
    int m_left    = 0;
    int m_snap_ms = 0;
    int m_snap_s  = 0;
    int m_clr     = 0;

    stopwatch_lap_cu #(
        .LAP_HOLD_CYC(HOLD),
        .TMR_W       (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_runstop   (i_runstop),
        .i_clear     (i_clear),
        .i_lap       (i_lap),
        .i_msec      (i_msec),
        .i_sec       (i_sec),
        .o_runstop   (o_runstop),
        .o_clear     (o_clear),
        .o_msec      (o_msec),
        .o_sec       (o_sec),
        .o_lap_active(o_lap_active),
        .o_state     (o_state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural step for one clock edge, using the inputs present at it.
    task automatic model_step(input bit r, input bit rs, input bit cl, input bit lp,
                              input int ms, input int s);
        int pick;
        m_clr = 0;
        if (!r) begin
            m_mode = M_IDLE; m_left = 0; m_snap_ms = 0; m_snap_s = 0;
            return;
        end
        pick = rs ? 1 : (cl ? 2 : (lp ? 3 : 0));
        case (m_mode)
            M_IDLE: begin
                if (pick == 1) m_mode = M_RUN;
                else if (pick == 2) m_clr = 1;
            end
            M_RUN: begin
                if (pick == 1) m_mode = M_STOP;
                else if (pick == 3) begin
                    m_mode = M_LAP; m_snap_ms = ms; m_snap_s = s; m_left = HOLD;
                end
            end
            M_LAP: begin
                if (pick == 1) m_mode = M_STOP;
                else if (pick == 3) begin
                    m_snap_ms = ms; m_snap_s = s; m_left = HOLD;
                end else begin
                    m_left--;
                    if (m_left == 0) m_mode = M_RUN;
                end
            end
            default: begin
                if (pick == 1) m_mode = M_RUN;
                else if (pick == 2) begin
                    m_mode = M_IDLE; m_clr = 1; m_snap_ms = 0; m_snap_s = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all(input string tag);
        int lap_on;
        lap_on = (m_mode == M_LAP);
        check_val({tag, "_state"},   int'(o_state),      m_mode);
        check_val({tag, "_runstop"}, int'(o_runstop),    int'(m_mode == M_RUN || m_mode == M_LAP));
        check_val({tag, "_clear"},   int'(o_clear),      m_clr);
        check_val({tag, "_lapact"},  int'(o_lap_active), lap_on);
        check_val({tag, "_msec"},    int'(o_msec),       lap_on ? m_snap_ms : int'(i_msec));
        check_val({tag, "_sec"},     int'(o_sec),        lap_on ? m_snap_s  : int'(i_sec));
    endtask

    // Drive at the falling edge, clock once, check at the next falling edge.
    task automatic cycle(input string tag, input bit r, input bit rs, input bit cl,
                         input bit lp, input int ms, input int s);
        rst = r; i_runstop = rs; i_clear = cl; i_lap = lp;
        i_msec = 7'(ms); i_sec = 6'(s);
        @(posedge clk);
        model_step(r, rs, cl, lp, ms, s);
        @(negedge clk);
        compare_all(tag);
        i_runstop = 1'b0; i_clear = 1'b0; i_lap = 1'b0;
    endtask

    task automatic idle_cyc(input string tag, input int ms, input int s);
        cycle(tag, 1'b1, 1'b0, 1'b0, 1'b0, ms, s);
    endtask

    initial begin
        rst = 1'b0; i_runstop = 1'b0; i_clear = 1'b0; i_lap = 1'b0;
        i_msec = '0; i_sec = '0;
        @(negedge clk);

        // 1. Reset held with every pulse asserted
        for (int k = 0; k < 3; k++) cycle("rst", 1'b0, 1'b1, 1'b1, 1'b1, 33, 12);
        check_val("rst_state",   int'(o_state), 0);
        check_val("rst_runstop", int'(o_runstop), 0);
        check_val("rst_clear",   int'(o_clear), 0);
        check_val("rst_lapact",  int'(o_lap_active), 0);
        check_val("rst_msec",    int'(o_msec), 33);

        // 2. Run / stop / clear
        cycle("t2_run", 1'b1, 1'b1, 1'b0, 1'b0, 1, 0);
        check_val("t2_run_state", int'(o_state), 1);
        check_val("t2_run_rs",    int'(o_runstop), 1);
        cycle("t2_stop", 1'b1, 1'b1, 1'b0, 1'b0, 2, 0);
        check_val("t2_stop_state", int'(o_state), 2);
        check_val("t2_stop_rs",    int'(o_runstop), 0);
        cycle("t2_clr", 1'b1, 1'b0, 1'b1, 1'b0, 3, 0);
        check_val("t2_clr_pulse", int'(o_clear), 1);
        check_val("t2_clr_state", int'(o_state), 0);
        idle_cyc("t2_after", 3, 0);
        check_val("t2_clr_once", int'(o_clear), 0);

        // 3. Lap hold window
        cycle("t3_run", 1'b1, 1'b1, 1'b0, 1'b0, 40, 17);
        cycle("t3_lap", 1'b1, 1'b0, 1'b0, 1'b1, 42, 17);
        check_val("t3_lapact", int'(o_lap_active), 1);
        check_val("t3_msec",   int'(o_msec), 42);
        check_val("t3_sec",    int'(o_sec), 17);
        for (int k = 1; k < HOLD; k++) begin
            idle_cyc("t3_hold", 43 + k, 17);
            check_val("t3_hold_msec", int'(o_msec), 42);
            check_val("t3_hold_rs",   int'(o_runstop), 1);
        end
        idle_cyc("t3_back", 60, 18);
        check_val("t3_back_state", int'(o_state), 1);
        check_val("t3_back_msec",  int'(o_msec), 60);
        check_val("t3_back_rs",    int'(o_runstop), 1);

        // 4. Recapture at timer=5, then runstop out of LAP
        cycle("t4_lap", 1'b1, 1'b0, 1'b0, 1'b1, 10, 19);
        for (int k = 0; k < 5; k++) idle_cyc("t4_wait", 11 + k, 19);
        cycle("t4_relap", 1'b1, 1'b0, 1'b0, 1'b1, 55, 20);
        check_val("t4_relap_msec", int'(o_msec), 55);
        check_val("t4_relap_sec",  int'(o_sec), 20);
        for (int k = 1; k < HOLD; k++) begin
            idle_cyc("t4_hold", 70 + k, 21);
            check_val("t4_hold_lapact", int'(o_lap_active), 1);
            check_val("t4_hold_msec",   int'(o_msec), 55);
        end
        idle_cyc("t4_exp", 90, 21);
        check_val("t4_exp_state", int'(o_state), 1);
        cycle("t4_lap2", 1'b1, 1'b0, 1'b0, 1'b1, 5, 22);
        cycle("t4_rs", 1'b1, 1'b1, 1'b0, 1'b0, 6, 22);
        check_val("t4_rs_state",  int'(o_state), 2);
        check_val("t4_rs_lapact", int'(o_lap_active), 0);
        check_val("t4_rs_msec",   int'(o_msec), 6);

        // 5. Priority and ignored pulses
        cycle("t5_all", 1'b1, 1'b1, 1'b1, 1'b1, 7, 23);
        check_val("t5_all_state", int'(o_state), 1);
        check_val("t5_all_clear", int'(o_clear), 0);
        cycle("t5_clr_run", 1'b1, 1'b0, 1'b1, 1'b0, 8, 23);
        check_val("t5_clr_run_state", int'(o_state), 1);
        check_val("t5_clr_run_clear", int'(o_clear), 0);
        cycle("t5_stop", 1'b1, 1'b1, 1'b0, 1'b0, 9, 23);
        cycle("t5_lap_stop", 1'b1, 1'b0, 1'b0, 1'b1, 9, 23);
        check_val("t5_lap_stop_state", int'(o_state), 2);

        // 6. Reset in the middle of LAP
        cycle("t6_run", 1'b1, 1'b1, 1'b0, 1'b0, 30, 40);
        cycle("t6_lap", 1'b1, 1'b0, 1'b0, 1'b1, 31, 41);
        for (int k = 0; k < 3; k++) idle_cyc("t6_wait", 32 + k, 41);
        cycle("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0, 50, 42);
        check_val("t6_rst_state", int'(o_state), 0);
        check_val("t6_rst_rs",    int'(o_runstop), 0);
        check_val("t6_rst_lapms", int'(dut.lap_msec_q), 0);
        check_val("t6_rst_lapsc", int'(dut.lap_sec_q), 0);
        cycle("t6_restart", 1'b1, 1'b1, 1'b0, 1'b0, 51, 42);
        check_val("t6_restart_state", int'(o_state), 1);

        // Randomized pulses, data and occasional resets
        for (int n = 0; n < 3000; n++) begin
            bit r, rs, cl, lp;
            r  = ($urandom_range(0, 63) != 0);
            rs = ($urandom_range(0, 9) == 0);
            cl = ($urandom_range(0, 5) == 0);
            lp = ($urandom_range(0, 5) == 0);
            if (cl && lp && !rs) begin
                if ($urandom_range(0, 1) == 0) cl = 1'b0;
                else lp = 1'b0;
            end
            cycle("rnd", r, rs, cl, lp, $urandom_range(0, 99), $urandom_range(0, 59));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
